mdu_div_seq: RTL and testbench

Multi-cycle divide sequencer for the M-extension DIV/DIVU/REM/REMU instructions. The decoder marks these with `alu_mul_sel=1` and a 4-bit `mul_con` op code; this block runs a 32-iteration restoring divider and stalls the pipeline until the result is ready. It sits in the execute stage beside the ALU. Its result is selected onto the write-back path in the cycle `done` is high.

---
 rtl/mdu_div_seq.sv | 174 +++++++++++++++++
 tb/tb_mdu_div_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU. It stalls the pipeline while it runs
// and pulses done for one cycle when result is valid.
//
// state | meaning
// IDLE  | waiting for an accepted start
// ITER  | one restoring-division step per cycle, XLEN steps
// FIX   | sign-correct quotient or remainder into result
// DONE  | result valid, done pulse; start ignored (same instruction still in EX)
`timescale 1ns/1ps
module mdu_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quot_q, neg_quot_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              is_signed;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, ovf;
  logic [XLEN:0]     rem_shift, rem_sub;
  logic              ge;
  logic [XLEN-1:0]   fix_val;
  logic              unused_ok;

  always_comb begin
    is_signed = !op[0];
    a_neg     = is_signed && dividend[XLEN-1];
    b_neg     = is_signed && divisor[XLEN-1];
    a_mag     = a_neg ? -dividend : dividend;
    b_mag     = b_neg ? -divisor : divisor;
    div_zero  = (divisor == '0);
    ovf       = is_signed && (dividend == INT_MIN) && (divisor == '1);
    accept    = (state_q == S_IDLE) && start && !flush && op[3];
    unused_ok = op[2];

    // rem_q[XLEN] is always zero between steps, so the shift only needs the low bits.
    rem_shift = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
    rem_sub   = rem_shift - {1'b0, dvsr_q};
    ge        = (rem_shift >= {1'b0, dvsr_q});

    if (is_rem_q) begin
      fix_val = neg_rem_q ? XLEN'(-rem_q) : rem_q[XLEN-1:0];
    end else begin
      fix_val = neg_quot_q ? -quot_q : quot_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    is_rem_d   = is_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_rem_d   = op[1];
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          dvsr_d     = b_mag;
          if (div_zero) begin
            state_d  = S_DONE;
            result_d = op[1] ? dividend : '1;
          end else if (ovf) begin
            state_d  = S_DONE;
            result_d = op[1] ? '0 : INT_MIN;
          end else begin
            state_d  = S_ITER;
            cnt_d    = '0;
            rem_d    = '0;
            quot_d   = a_mag;
          end
        end
      end
      S_ITER: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = ge ? rem_sub : rem_shift;
          quot_d = {quot_q[XLEN-2:0], ge};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_val;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      is_rem_q   <= is_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // stall must rise in the start cycle itself, so it looks at the live request.
  assign stall  = accept || (state_q == S_ITER) || (state_q == S_FIX);
  assign done   = done_q;
  assign busy   = busy_q;
  assign result = result_q;

endmodule

// File: tb/tb_mdu_div_seq.sv
// Testbench for mdu_div_seq: directed divides against literal results, plus a latency-level
// model of stall/done/busy/result checked every cycle.
`timescale 1ns/1ps
module tb_mdu_div_seq;

  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REM  = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'b0000;
  logic        flush = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        stall, done, busy;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;

  // model: m_k = cycles since accepted start (0 = idle), m_lat = cycle index of done
  int          m_k = 0;
  int          m_lat = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;

  mdu_div_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
    .dividend(dividend), .divisor(divisor),
    .stall(stall), .done(done), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit is_special(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] golden(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (o[1:0])
      2'b00:   if (b == 0) return 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
               else return 32'(sa / sb);
      2'b10:   if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
               else return 32'(sa % sb);
      2'b01:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_stall, e_done, e_busy;
      if (m_k == 0) begin
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_stall = start && !flush && op[3];
      end else if (m_k == m_lat) begin
        e_busy  = 1'b1;
        e_done  = 1'b1;
        e_stall = 1'b0;
      end else begin
        e_busy  = 1'b1;
        e_done  = 1'b0;
        e_stall = 1'b1;
      end
      chk("cyc_stall", {31'd0, stall}, {31'd0, e_stall});
      chk("cyc_done", {31'd0, done}, {31'd0, e_done});
      chk("cyc_busy", {31'd0, busy}, {31'd0, e_busy});
      chk("cyc_result", result, m_res);
      if (done === 1'b1) done_cnt++;

      if (rst) begin
        m_k   = 0;
        m_res = '0;
      end else if (m_k == 0) begin
        if (start && !flush && op[3]) begin
          m_pend = golden(op, dividend, divisor);
          m_lat  = is_special(op, dividend, divisor) ? 1 : 34;
          m_k    = 1;
          if (m_lat == 1) m_res = m_pend;
        end
      end else if (m_k == m_lat) begin
        m_k = 0;
      end else if (flush) begin
        m_k = 0;
      end else begin
        m_k++;
        if (m_k == m_lat) m_res = m_pend;
      end
    end
  end

  // Called #1 after a rising edge; that cycle is cycle 0.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_cyc, input bit keep_start);
    int n;
    int stalls;
    bit got;
    n = 0;
    stalls = 0;
    got = 1'b0;
    start = 1'b1;
    op = o;
    dividend = a;
    divisor = b;
    while (!got && n < 60) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else begin
        if (stall === 1'b1) stalls++;
        n++;
      end
    end
    chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({name, "_latency"}, n, exp_cyc);
    chk({name, "_stall_cycles"}, stalls, exp_cyc);
    chk({name, "_result"}, result, exp_res);
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prior;
    int d0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_result", result, 32'd0);
    step();
    chk_en = 1'b1;

    run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
    run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34, 0);
    run_op("remu_100_7", OP_REMU, 32'd100,       32'd7,         32'd2,         34, 0);
    run_op("div_5_0",    OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
    run_op("rem_5_0",    OP_REM,  32'd5,         32'd0,         32'd5,         1, 0);
    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);
    run_op("divu_nosp",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, 0);
    run_op("div_100_m7", OP_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 0);
    run_op("rem_100_m7", OP_REM,  32'd100,       32'hFFFF_FFF9, 32'd2,         34, 0);
    run_op("div_m100_m7",OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        34, 0);
    run_op("rem_m100_m7",OP_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34, 0);
    run_op("remu_neg_0", OP_REMU, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 1, 0);

    // flush in cycle 10 of a DIV
    prior = result;
    start = 1'b1; op = OP_DIV; dividend = 32'd1000; divisor = 32'd7;
    repeat (10) step();
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("flush_c10_stall", {31'd0, stall}, 32'd1);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_after_stall", {31'd0, stall}, 32'd0);
    chk("flush_after_busy", {31'd0, busy}, 32'd0);
    chk("flush_after_result", result, prior);
    d0 = done_cnt;
    repeat (40) step();
    chk("flush_no_done", done_cnt - d0, 32'd0);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 0);

    // start with flush in IDLE, and a start whose op[3] is clear
    start = 1'b1; flush = 1'b1; op = OP_DIV; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    chk("idle_flush_stall", {31'd0, stall}, 32'd0);
    step();
    flush = 1'b0; op = 4'b0001;
    @(negedge clk);
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);
    chk("op3_clear_stall", {31'd0, stall}, 32'd0);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("op3_clear_busy", {31'd0, busy}, 32'd0);
    step();

    // reset mid-ITER
    start = 1'b1; op = OP_DIV; dividend = 32'd77; divisor = 32'd4;
    repeat (5) step();
    rst = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    step();

    // back-to-back with start held through DONE
    d0 = done_cnt;
    run_op("b2b_first",  OP_DIV, 32'd20,        32'd3, 32'd6,         34, 1);
    run_op("b2b_second", OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, 0);
    repeat (5) step();
    chk("b2b_done_pulses", done_cnt - d0, 32'd2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
